// File: rtl/subdiv_stage_ctrl.sv
// Top-level sequencer for the subdivision datapath: header read, capacity check,
// in-order stage launch and OBJ RAM port arbitration. Optional: SUBDIV_STAGE_CTRL_PERF_EN.
module subdiv_stage_ctrl #(
  parameter int ADDR_WIDTH         = 9,
  parameter int NUM_STAGES         = 2,
  parameter int MAX_NEIGHBOR_COUNT = 10,
  parameter int ACK_TIMEOUT        = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  output logic                             done,
  output logic                             error,
  output logic [1:0]                       err_code,
  output logic [2:0]                       err_stage,
  output logic [31:0]                      vertex_count,
  output logic [31:0]                      face_count,
  output logic [NUM_STAGES-1:0]            stage_start,
  input  logic [NUM_STAGES-1:0]            stage_busy,
  input  logic [NUM_STAGES-1:0]            stage_obj_en,
  input  logic [NUM_STAGES*4-1:0]          stage_obj_we,
  input  logic [NUM_STAGES*ADDR_WIDTH-1:0] stage_obj_a,
  input  logic [NUM_STAGES*32-1:0]         stage_obj_di,
  output logic                             RAM_OBJ_EN,
  output logic [3:0]                       RAM_OBJ_WE,
  output logic [ADDR_WIDTH-1:0]            RAM_OBJ_A,
  output logic [31:0]                      RAM_OBJ_Di,
  input  logic [31:0]                      RAM_OBJ_Do,
  output logic [31:0]                      stage_obj_do,
  output logic [2:0]                       cur_stage,
  output logic                             busy
`ifdef SUBDIV_STAGE_CTRL_PERF_EN
  ,
  output logic [NUM_STAGES*32-1:0]         cycle_count
`endif
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_HDR_A0    = 4'd1;
  localparam logic [3:0] S_HDR_A1    = 4'd2;
  localparam logic [3:0] S_HDR_VC    = 4'd3;
  localparam logic [3:0] S_HDR_FC    = 4'd4;
  localparam logic [3:0] S_CHECK     = 4'd5;
  localparam logic [3:0] S_LAUNCH    = 4'd6;
  localparam logic [3:0] S_WAIT_ACK  = 4'd7;
  localparam logic [3:0] S_WAIT_DONE = 4'd8;
  localparam logic [3:0] S_NEXT      = 4'd9;
  localparam logic [3:0] S_FINISH    = 4'd10;
  localparam logic [3:0] S_FAULT     = 4'd11;

  localparam int SEL_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] ACK_LAST  = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [39:0]      RAM_DEPTH = 40'd1 << ADDR_WIDTH;

  logic [3:0]            state;
  logic [TMO_W-1:0]      ack_cnt;
  logic [SEL_W-1:0]      sel;
  logic                  granted;
  logic [39:0]           obj_words;
  logic [39:0]           nbr_words;

  logic                  req_en [NUM_STAGES];
  logic [3:0]            req_we [NUM_STAGES];
  logic [ADDR_WIDTH-1:0] req_a  [NUM_STAGES];
  logic [31:0]           req_di [NUM_STAGES];

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_unpack
    assign req_en[g] = stage_obj_en[g];
    assign req_we[g] = stage_obj_we[g*4 +: 4];
    assign req_a[g]  = stage_obj_a[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_di[g] = stage_obj_di[g*32 +: 32];
  end

  assign sel          = cur_stage[SEL_W-1:0];
  assign granted      = (state == S_LAUNCH) || (state == S_WAIT_ACK) || (state == S_WAIT_DONE);
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_FINISH) || (state == S_FAULT);
  assign stage_obj_do = RAM_OBJ_Do;

  // Header counts are zero-extended so the sums and products cannot wrap.
  assign obj_words = 40'd2 + 40'd3 * {8'd0, vertex_count} + 40'd3 * {8'd0, face_count};
  assign nbr_words = {8'd0, vertex_count} * 40'(MAX_NEIGHBOR_COUNT);

  // NOTE: every signal assigned in always_comb gets a default first; otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    RAM_OBJ_EN = 1'b0;
    RAM_OBJ_WE = 4'h0;
    RAM_OBJ_A  = '0;
    RAM_OBJ_Di = 32'h0;
    case (state)
      S_HDR_A0: RAM_OBJ_EN = 1'b1;
      S_HDR_A1: begin
        RAM_OBJ_EN = 1'b1;
        RAM_OBJ_A  = ADDR_WIDTH'(1);
      end
      S_LAUNCH, S_WAIT_ACK, S_WAIT_DONE: begin
        RAM_OBJ_EN = req_en[sel];
        RAM_OBJ_WE = req_we[sel];
        RAM_OBJ_A  = req_a[sel];
        RAM_OBJ_Di = req_di[sel];
      end
      default: ;
    endcase
  end

  // Gated by rst so a reset landing on a LAUNCH cycle never emits a pulse.
  always_comb begin
    stage_start = '0;
    if (state == S_LAUNCH && !rst) stage_start[sel] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      ack_cnt      <= '0;
      cur_stage    <= 3'd0;
      error        <= 1'b0;
      err_code     <= 2'd0;
      err_stage    <= 3'd0;
      vertex_count <= 32'd0;
      face_count   <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            error     <= 1'b0;
            err_code  <= 2'd0;
            err_stage <= 3'd0;
            cur_stage <= 3'd0;
            state     <= S_HDR_A0;
          end
        end
        S_HDR_A0: state <= S_HDR_A1;
        // Read data lags the address by one cycle, so each count is captured
        // on the edge that enters its named state.
        S_HDR_A1: begin
          vertex_count <= RAM_OBJ_Do;
          state        <= S_HDR_VC;
        end
        S_HDR_VC: begin
          face_count <= RAM_OBJ_Do;
          state      <= S_HDR_FC;
        end
        S_HDR_FC: state <= S_CHECK;
        S_CHECK: begin
          if (vertex_count == 32'd0 || face_count == 32'd0) begin
            error    <= 1'b1;
            err_code <= 2'd1;
            state    <= S_FAULT;
          end else if (obj_words > RAM_DEPTH || nbr_words > RAM_DEPTH) begin
            error    <= 1'b1;
            err_code <= 2'd2;
            state    <= S_FAULT;
          end else begin
            cur_stage <= 3'd0;
            state     <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          ack_cnt <= '0;
          state   <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (stage_busy[sel]) begin
            state <= S_WAIT_DONE;
          end else if (ack_cnt == ACK_LAST) begin
            error     <= 1'b1;
            err_code  <= 2'd3;
            err_stage <= cur_stage;
            state     <= S_FAULT;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: if (!stage_busy[sel]) state <= S_NEXT;
        S_NEXT: begin
          if (cur_stage == 3'(NUM_STAGES - 1)) begin
            state <= S_FINISH;
          end else begin
            cur_stage <= cur_stage + 3'd1;
            state     <= S_LAUNCH;
          end
        end
        S_FINISH, S_FAULT: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SUBDIV_STAGE_CTRL_PERF_EN
  logic [31:0] perf_cnt [NUM_STAGES];

  // NOTE: this array is a handful of flops, not a RAM, so resetting it is cheap
  // and keeps the counters defined from the first cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_STAGES; i++) perf_cnt[i] <= 32'd0;
    end else if (state == S_IDLE && start) begin
      for (int i = 0; i < NUM_STAGES; i++) perf_cnt[i] <= 32'd0;
    end else if (granted) begin
      perf_cnt[sel] <= perf_cnt[sel] + 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_perf
    assign cycle_count[g*32 +: 32] = perf_cnt[g];
  end
`endif

endmodule

// File: tb/tb_subdiv_stage_ctrl.sv
// Directed self-checking bench for subdiv_stage_ctrl: behavioural OBJ RAM and
// two negedge-clocked stage models with controllable acknowledge.
module tb_subdiv_stage_ctrl;

  localparam int AW   = 9;
  localparam int NS   = 2;
  localparam int BUSY_LEN = 50;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            done, error;
  logic [1:0]      err_code;
  logic [2:0]      err_stage;
  logic [31:0]     vertex_count, face_count;
  logic [NS-1:0]   stage_start;
  logic [NS-1:0]   stage_busy;
  logic [NS-1:0]   stage_obj_en;
  logic [NS*4-1:0] stage_obj_we;
  logic [NS*AW-1:0] stage_obj_a;
  logic [NS*32-1:0] stage_obj_di;
  logic            RAM_OBJ_EN;
  logic [3:0]      RAM_OBJ_WE;
  logic [AW-1:0]   RAM_OBJ_A;
  logic [31:0]     RAM_OBJ_Di;
  logic [31:0]     RAM_OBJ_Do;
  logic [31:0]     stage_obj_do;
  logic [2:0]      cur_stage;
  logic            busy;
`ifdef SUBDIV_STAGE_CTRL_PERF_EN
  logic [NS*32-1:0] cycle_count;
`endif

  subdiv_stage_ctrl #(
    .ADDR_WIDTH(AW), .NUM_STAGES(NS), .MAX_NEIGHBOR_COUNT(10), .ACK_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .done(done), .error(error),
    .err_code(err_code), .err_stage(err_stage),
    .vertex_count(vertex_count), .face_count(face_count),
    .stage_start(stage_start), .stage_busy(stage_busy),
    .stage_obj_en(stage_obj_en), .stage_obj_we(stage_obj_we),
    .stage_obj_a(stage_obj_a), .stage_obj_di(stage_obj_di),
    .RAM_OBJ_EN(RAM_OBJ_EN), .RAM_OBJ_WE(RAM_OBJ_WE), .RAM_OBJ_A(RAM_OBJ_A),
    .RAM_OBJ_Di(RAM_OBJ_Di), .RAM_OBJ_Do(RAM_OBJ_Do),
    .stage_obj_do(stage_obj_do), .cur_stage(cur_stage), .busy(busy)
`ifdef SUBDIV_STAGE_CTRL_PERF_EN
    , .cycle_count(cycle_count)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read OBJ RAM with byte writes; Do updates one edge after EN.
  logic [31:0] mem [2**AW];
  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = 32'd0;
    RAM_OBJ_Do = 32'd0;
    forever begin
      @(posedge clk);
      if (RAM_OBJ_EN) begin
        RAM_OBJ_Do <= mem[RAM_OBJ_A];
        for (int b = 0; b < 4; b++)
          if (RAM_OBJ_WE[b]) mem[RAM_OBJ_A][8*b +: 8] = RAM_OBJ_Di[8*b +: 8];
      end
    end
  end

  // Stage models: busy rises two negedges after the start pulse, stays BUSY_LEN cycles.
  logic [NS-1:0] ack_en;
  int dly [NS];
  int run [NS];
  initial begin
    stage_busy = '0;
    for (int i = 0; i < NS; i++) begin dly[i] = 0; run[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
        if (rst) begin
          stage_busy[i] = 1'b0; dly[i] = 0; run[i] = 0;
        end else if (stage_busy[i]) begin
          run[i]--;
          if (run[i] == 0) stage_busy[i] = 1'b0;
        end else if (dly[i] > 0) begin
          dly[i]--;
          if (dly[i] == 0) begin stage_busy[i] = 1'b1; run[i] = BUSY_LEN; end
        end else if (stage_start[i] && ack_en[i]) begin
          dly[i] = 2;
        end
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int n_done, n_start0, n_start1, c_start0, c_start1, c_done, c_fall0;
  logic [AW-1:0] a_s0, a_s1;
  logic [3:0]    we_s0;
  logic          err_d;
  logic [1:0]    code_d;
  logic [2:0]    stage_d;

  task automatic set_header(input logic [31:0] vc, input logic [31:0] fc);
    mem[0] = vc;
    mem[1] = fc;
  endtask

  task automatic run_and_watch(input int budget, input bit poke_start);
    int  cyc;
    logic prev_b0;
    n_done = 0; n_start0 = 0; n_start1 = 0;
    c_start0 = -1; c_start1 = -1; c_done = -1; c_fall0 = -1;
    a_s0 = '0; a_s1 = '0; we_s0 = '0; err_d = 1'b0; code_d = 2'd0; stage_d = 3'd0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    prev_b0 = 1'b0;
    while (cyc < budget && !(c_done >= 0 && cyc > c_done + 3)) begin
      if (stage_start[0]) begin n_start0++; c_start0 = cyc; a_s0 = RAM_OBJ_A; we_s0 = RAM_OBJ_WE; end
      if (stage_start[1]) begin n_start1++; c_start1 = cyc; a_s1 = RAM_OBJ_A; end
      if (done) begin
        n_done++; c_done = cyc; err_d = error; code_d = err_code; stage_d = err_stage;
      end
      if (prev_b0 && !stage_busy[0]) c_fall0 = cyc;
      prev_b0 = stage_busy[0];
      start = poke_start && (cyc == 20);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (c_done < 0) check("done_within_budget", 64'(c_done), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    ack_en = 2'b11;
    stage_obj_en = 2'b11;
    stage_obj_we = {4'h0, 4'hF};
    stage_obj_a  = {9'h0AA, 9'h1F0};
    stage_obj_di = {32'h0000_0000, 32'hCAFE_F00D};
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_done",   done, 0);
    check("rst_error",  {error, err_code, err_stage}, 0);
    check("rst_counts", {vertex_count, face_count}, 0);
    check("rst_busy",   {busy, cur_stage, stage_start}, 0);
    check("rst_ram_en", {RAM_OBJ_EN, RAM_OBJ_WE}, 0);

    // Nominal two-stage run, with a stray start while busy
    set_header(32'd8, 32'd12);
    run_and_watch(400, 1'b1);
    check("t1_done_once",   n_done, 1);
    check("t1_error",       {err_d, code_d}, 0);
    check("t1_starts",      {8'(n_start0), 8'(n_start1)}, {8'd1, 8'd1});
    check("t1_order",       (c_fall0 > c_start0) && (c_start1 > c_fall0), 1);
    check("t1_vc",          vertex_count, 32'd8);
    check("t1_fc",          face_count, 32'd12);
    check("t1_mux_s0_a",    a_s0, 9'h1F0);
    check("t1_mux_s0_we",   we_s0, 4'hF);
    check("t1_mux_s1_a",    a_s1, 9'h0AA);
    check("t1_idle_after",  {busy, RAM_OBJ_EN}, 0);

    // Empty mesh
    set_header(32'd0, 32'd12);
    run_and_watch(100, 1'b0);
    check("vc0_done",  n_done, 1);
    check("vc0_err",   {err_d, code_d}, {1'b1, 2'd1});
    check("vc0_no_ss", n_start0 + n_start1, 0);

    // Neighbour capacity overflow: 60*10 = 600 > 512
    set_header(32'd60, 32'd12);
    run_and_watch(100, 1'b0);
    check("nbr_ovf_err",   {err_d, code_d}, {1'b1, 2'd2});
    check("nbr_ovf_no_ss", n_start0 + n_start1, 0);

    // Stage 1 never acknowledges: FAULT 17 cycles after its LAUNCH cycle
    set_header(32'd8, 32'd12);
    ack_en = 2'b01;
    run_and_watch(400, 1'b0);
    check("tmo_latency", 64'(c_done - c_start1), 64'd17);
    check("tmo_err",     {err_d, code_d, stage_d}, {1'b1, 2'd3, 3'd1});
    check("tmo_sticky",  {busy, error, err_code}, {1'b0, 1'b1, 2'd3});
    ack_en = 2'b11;

    // Object words exactly at capacity: 2 + 30 + 480 = 512
    set_header(32'd10, 32'd160);
    run_and_watch(400, 1'b0);
    check("cap512_ok",   {err_d, code_d}, 0);
    check("cap512_runs", {8'(n_start0), 8'(n_start1), 8'(n_done)}, {8'd1, 8'd1, 8'd1});

    // One face over: 2 + 30 + 483 = 515
    set_header(32'd10, 32'd161);
    run_and_watch(100, 1'b0);
    check("cap515_err", {err_d, code_d}, {1'b1, 2'd2});

    // 3*fc wraps to 2 at 32 bits; must still overflow at full width
    set_header(32'd1, 32'h5555_5556);
    run_and_watch(100, 1'b0);
    check("wide_err",   {err_d, code_d}, {1'b1, 2'd2});
    check("wide_no_ss", n_start0, 0);

    // Reset during WAIT_DONE of stage 0, then a clean rerun
    set_header(32'd8, 32'd12);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 60 && !stage_busy[0]; i++) @(negedge clk);
    check("mid_reached_busy", stage_busy[0], 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_idle",  {busy, done, stage_start}, 0);
    check("mid_rst_regs",  {vertex_count, cur_stage}, 0);
    @(negedge clk);
    check("mid_rst_no_ss", stage_start, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    set_header(32'd5, 32'd12);
    run_and_watch(400, 1'b0);
    check("rerun_done",   {8'(n_done), 8'(n_start0), 8'(n_start1)}, {8'd1, 8'd1, 8'd1});
    check("rerun_err",    {err_d, code_d}, 0);
    check("rerun_vc",     vertex_count, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/subdiv_stage_ctrl.md
Name: subdiv_stage_ctrl

Overview:
- Top-level sequencer for the subdivision datapath.
- Reads the mesh header (vertex_count, face_count) from OBJ RAM and validates it against RAM capacity.
- Launches NUM_STAGES stages in order (stage 0 = neighbor builder, then later stages) using their start/busy handshake.
- Owns the single OBJ RAM port and muxes it to whichever stage is active.

Parameters:
- ADDR_WIDTH, 9, RAM address width; RAM depth is 2**ADDR_WIDTH words.
- NUM_STAGES, 2, number of sequenced stages (1..8).
- MAX_NEIGHBOR_COUNT, 10, words per vertex in the NBR RAM layout; used in the capacity check.
- ACK_TIMEOUT, 16, cycles allowed between a stage start pulse and that stage's busy rising.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- start  in  1  run request; sampled only in IDLE.
- done  out  1  one-cycle pulse when all stages have completed.
- error  out  1  sticky; set on a header or timeout fault; cleared by rst or by the next accepted start.
- err_code  out  2  0 none, 1 empty mesh, 2 capacity overflow, 3 ack timeout.
- err_stage  out  3  index of the stage that timed out.
- vertex_count, face_count  out  32 each  latched header values, driven to all stages.
- stage_start  out  NUM_STAGES  one-hot, one-cycle launch pulse.
- stage_busy  in  NUM_STAGES  per-stage busy.
- stage_obj_en, stage_obj_we(4/stage), stage_obj_a(ADDR_WIDTH/stage), stage_obj_di(32/stage)  in  flattened  per-stage OBJ RAM requests.
- RAM_OBJ_EN  out  1;  RAM_OBJ_WE  out  4;  RAM_OBJ_A  out  ADDR_WIDTH;  RAM_OBJ_Di  out  32.
- RAM_OBJ_Do  in  32  RAM read data; available one cycle after address/EN.
- stage_obj_do  out  32  RAM_OBJ_Do forwarded to all stages.
- cur_stage  out  3  active stage index.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0. Reset mid-run returns to IDLE within 1 cycle and stage_start is never asserted during rst.
- RAM layout: addr 0 = vertex_count, addr 1 = face_count, then 3 words per vertex, then 3 words per face.
- State machine:
  - IDLE: on start, clear error/err_code and go to HDR_A0.
  - HDR_A0: RAM_OBJ_EN=1, WE=0, A=0.
  - HDR_A1: A=1.
  - HDR_VC: latch vertex_count from Do.
  - HDR_FC: latch face_count from Do.
  - CHECK:
    - If vertex_count==0 or face_count==0: err_code=1, go to FAULT.
    - Else if 2+3*vc+3*fc > 2**ADDR_WIDTH or vc*MAX_NEIGHBOR_COUNT > 2**ADDR_WIDTH: err_code=2, go to FAULT.
    - Else cur_stage=0, go to LAUNCH.
    - All products computed at 40-bit width, no truncation.
  - LAUNCH: stage_start[cur_stage]=1 for exactly one cycle; the RAM port is granted to cur_stage from this cycle; go to WAIT_ACK.
  - WAIT_ACK:
    - On stage_busy[cur_stage]==1, go to WAIT_DONE.
    - Otherwise count cycles; at ACK_TIMEOUT: err_code=3, err_stage=cur_stage, go to FAULT.
    - Stages clock on negedge, so busy normally rises within 1-2 cycles.
  - WAIT_DONE: on stage_busy[cur_stage]==0, go to NEXT.
  - NEXT: if cur_stage==NUM_STAGES-1, go to FINISH; else increment cur_stage and go to LAUNCH.
  - FINISH: done=1 for one cycle, go to IDLE.
  - FAULT: error=1, done=1 for one cycle, go to IDLE.
- Port mux:
  - In HDR_* states the controller drives RAM_OBJ_*.
  - In LAUNCH, WAIT_ACK and WAIT_DONE the RAM_OBJ_* outputs are combinationally equal to stage cur_stage's inputs.
  - Otherwise EN=0, WE=0.
  - Requests from non-granted stages are ignored.
- start while busy is ignored.
- Busy asserted by a non-current stage has no effect.
- vertex_count/face_count hold their values until the next accepted start.

Optional Feature:
- SUBDIV_STAGE_CTRL_PERF_EN: adds output cycle_count[NUM_STAGES*32].
  - Each stage's entry counts cycles spent in LAUNCH through WAIT_DONE.
  - Entries are cleared on an accepted start and held after done.
- Without the macro the port and the counters are absent.

Test Plan:
- Header vc=8, fc=12, two model stages, each busy 2 cycles after start for 50 cycles:
  - stage_start[0] pulses, then stage_start[1] pulses only after busy[0] falls.
  - done pulses once; error=0; vertex_count=8, face_count=12.
- Header vc=0: err_code=1, error=1, done pulses, no stage_start.
- Header vc=60 with MAX_NEIGHBOR_COUNT=10 (600 > 512): err_code=2, no stage_start.
- Stage 1 never raises busy, ACK_TIMEOUT=16: error after exactly 16 WAIT_ACK cycles; err_code=3, err_stage=1.
- Port mux: stage 0 drives A=0x1F0, WE=0xF while stage 1 drives A=0x0AA:
  - During stage 0, RAM_OBJ_A=0x1F0 and WE=0xF.
  - During stage 1, RAM_OBJ_A=0x0AA.
- rst asserted during WAIT_DONE of stage 0: next cycle state IDLE, busy=0, done=0; a second start reruns cleanly from the header read.
